reset_sequencer: RTL and testbench

Chip-level reset controller that drives the per-domain reset synchronizer chain for a set of subsystems. It synchronizes deassertion of async_rst internally, then releases NUM_STAGES stage resets one at a time in a fixed order with programmable hold and gap delays. It also supports a software-requested soft reset that re-runs the same sequence. Stage outputs feed downstream per-domain reset synchronizers, such as the async FIFO endpoints and the datapath blocks.

---
 rtl/reset_sequencer.sv | 116 +++++++++++
 tb/tb_reset_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Chip-level reset sequencer: synchronizes async_rst release, then drops per-stage resets in order
// after a hold delay and fixed gaps between stages; a soft reset request from DONE replays the sequence.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  sw_rst_ack
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [1:0]       sync_ff;
  logic             sync_rst;

  // Assertion is immediate; release reaches the FSM two edges later.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      sync_ff <= 2'b11;
    end else begin
      sync_ff <= {sync_ff[0], 1'b0};
    end
  end

  assign sync_rst = sync_ff[1];

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state      <= ST_RESET;
      cnt        <= '0;
      idx        <= '0;
      stage_rst  <= '1;
      seq_busy   <= 1'b0;
      seq_done   <= 1'b0;
      sw_rst_ack <= 1'b0;
    end else begin
      sw_rst_ack <= 1'b0;
      case (state)
        ST_RESET: begin
          if (!sync_rst) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            idx      <= '0;
            seq_busy <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            stage_rst[0] <= 1'b0;
            cnt          <= '0;
            idx          <= IDX_W'(1);
            if (NUM_STAGES == 1) begin
              state    <= ST_DONE;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            stage_rst <= stage_rst & ~(NUM_STAGES'(1) << idx);
            cnt       <= '0;
            idx       <= idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state    <= ST_DONE;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Requests are only honoured here; earlier ones are dropped, not queued.
          if (sw_rst_req) begin
            stage_rst  <= '1;
            sw_rst_ack <= 1'b1;
            state      <= ST_HOLD;
            cnt        <= '0;
            idx        <= '0;
            seq_busy   <= 1'b1;
            seq_done   <= 1'b0;
          end
        end
        default: begin
          state <= ST_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default instance plus two corner-parameter instances.
module tb_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [6:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       async_rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  int         cyc = -1;
  int         checks = 0;
  int         passes = 0;

  logic [3:0] m_stage;
  logic       m_busy, m_done, m_ack;
  logic [0:0] c1_stage;
  logic       c1_busy, c1_done, c1_ack;
  logic [2:0] c3_stage;
  logic       c3_busy, c3_done, c3_ack;

  ev_t        exp_q[3][$];
  logic [6:0] obs[3];
  logic [6:0] prev[3];
  bit         first[3] = '{1'b1, 1'b1, 1'b1};
  string      dname[3] = '{"main", "c1", "c3"};

  reset_sequencer u_main (
    .clk(clk), .async_rst(async_rst), .sw_rst_req(sw_rst_req),
    .stage_rst(m_stage), .seq_busy(m_busy), .seq_done(m_done), .sw_rst_ack(m_ack)
  );

  reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_c1 (
    .clk(clk), .async_rst(async_rst), .sw_rst_req(1'b0),
    .stage_rst(c1_stage), .seq_busy(c1_busy), .seq_done(c1_done), .sw_rst_ack(c1_ack)
  );

  reset_sequencer #(.NUM_STAGES(3), .HOLD_CYCLES(16), .GAP_CYCLES(1)) u_c3 (
    .clk(clk), .async_rst(async_rst), .sw_rst_req(1'b0),
    .stage_rst(c3_stage), .seq_busy(c3_busy), .seq_done(c3_done), .sw_rst_ack(c3_ack)
  );

  assign obs[0] = {m_stage, m_busy, m_done, m_ack};
  assign obs[1] = {3'b000, c1_stage, c1_busy, c1_done, c1_ack};
  assign obs[2] = {1'b0, c3_stage, c3_busy, c3_done, c3_ack};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int d, input int c, input logic [6:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_q[d].push_back(e);
  endtask

  // Soft-reset run on the 4-stage default instance accepted at edge t (HOLD entry at t).
  task automatic push_soft(input int t);
    push(0, t,      7'b1111_101);
    push(0, t + 1,  7'b1111_100);
    push(0, t + 16, 7'b1110_100);
    push(0, t + 24, 7'b1100_100);
    push(0, t + 32, 7'b1000_100);
    push(0, t + 40, 7'b0000_010);
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every output change on any instance is matched against the next expected event.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (first[d] || obs[d] !== prev[d]) begin
        checks++;
        if (exp_q[d].size() == 0) begin
          $display("FAIL %s unexpected change: cyc=%0d val=%b, no event expected", dname[d], cyc, obs[d]);
        end else begin
          ev_t e;
          e = exp_q[d].pop_front();
          if (e.cyc != cyc || e.val !== obs[d])
            $display("FAIL %s event: got cyc=%0d val=%b, want cyc=%0d val=%b",
                     dname[d], cyc, obs[d], e.cyc, e.val);
          else
            passes++;
        end
        prev[d]  = obs[d];
        first[d] = 1'b0;
      end
    end
  end

  initial begin
    // Main instance: {stage_rst[3:0], seq_busy, seq_done, sw_rst_ack}
    push(0, 0,  7'b1111_000);
    push(0, 3,  7'b1111_100);
    push(0, 19, 7'b1110_100);
    push(0, 27, 7'b1100_100);
    push(0, 35, 7'b1000_100);
    push(0, 43, 7'b0000_010);
    push_soft(50);              // request ignored at 77 leaves this timing untouched
    push(0, 100, 7'b1111_101);
    push(0, 101, 7'b1111_100);
    push(0, 116, 7'b1110_100);
    push(0, 124, 7'b1100_100);
    push(0, 130, 7'b1111_000);  // async reset between edges 130 and 131
    push(0, 135, 7'b1111_100);
    push(0, 151, 7'b1110_100);
    push(0, 159, 7'b1100_100);
    push(0, 167, 7'b1000_100);
    push(0, 175, 7'b0000_010);
    push(0, 180, 7'b1111_000);  // sub-cycle glitch
    push(0, 183, 7'b1111_100);
    push(0, 199, 7'b1110_100);
    push(0, 207, 7'b1100_100);
    push(0, 215, 7'b1000_100);
    push(0, 223, 7'b0000_010);
    push_soft(230);             // held request: retriggers on each DONE entry
    push_soft(271);
    push_soft(312);

    // One stage, hold 1, gap 1
    push(1, 0,   7'b0001_000);
    push(1, 3,   7'b0001_100);
    push(1, 4,   7'b0000_010);
    push(1, 130, 7'b0001_000);
    push(1, 135, 7'b0001_100);
    push(1, 136, 7'b0000_010);
    push(1, 180, 7'b0001_000);
    push(1, 183, 7'b0001_100);
    push(1, 184, 7'b0000_010);

    // Three stages, hold 16, gap 1: consecutive-edge releases
    push(2, 0,   7'b0111_000);
    push(2, 3,   7'b0111_100);
    push(2, 19,  7'b0110_100);
    push(2, 20,  7'b0100_100);
    push(2, 21,  7'b0000_010);
    push(2, 130, 7'b0111_000);
    push(2, 135, 7'b0111_100);
    push(2, 151, 7'b0110_100);
    push(2, 152, 7'b0100_100);
    push(2, 153, 7'b0000_010);
    push(2, 180, 7'b0111_000);
    push(2, 183, 7'b0111_100);
    push(2, 199, 7'b0110_100);
    push(2, 200, 7'b0100_100);
    push(2, 201, 7'b0000_010);

    #1 async_rst = 1'b1;
    wait_edge(0);
    #2 async_rst = 1'b0;

    wait_edge(49);  sw_rst_req = 1'b1;
    wait_edge(50);  sw_rst_req = 1'b0;
    wait_edge(76);  sw_rst_req = 1'b1;
    wait_edge(77);  sw_rst_req = 1'b0;
    wait_edge(99);  sw_rst_req = 1'b1;
    wait_edge(100); sw_rst_req = 1'b0;

    wait_edge(130); async_rst = 1'b1;
    wait_edge(132);
    #2 async_rst = 1'b0;

    wait_edge(180); async_rst = 1'b1;
    #2 async_rst = 1'b0;

    wait_edge(229); sw_rst_req = 1'b1;
    wait_edge(312); sw_rst_req = 1'b0;

    wait_edge(360);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (exp_q[d].size() != 0)
        $display("FAIL %s drained: got %0d events outstanding (next at cyc=%0d), want 0",
                 dname[d], exp_q[d].size(), exp_q[d][0].cyc);
      else
        passes++;
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
